// File: rtl/encoder_4x2_seq_if.sv
// rtl/encoder_4x2_seq_if.sv - request/result handshake bundle for encoder_4x2_seq
interface encoder_4x2_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] d;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] code;
  logic       hit;
  logic       err;

  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, code, hit, err
  );

  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, code, hit, err
  );
endinterface

// File: rtl/encoder_4x2_seq.sv
// rtl/encoder_4x2_seq.sv - registered 4-to-2 encoder with valid/ready handshake
// Optional rotating search start is enabled by defining ROUND_ROBIN_EN.
module encoder_4x2_seq #(
  parameter int MULTI_HOT_ERR = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  encoder_4x2_seq_if.slave     bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t     state;
  logic       accept;
  logic       nxt_hit;
  logic       nxt_err;
  logic       multi_hot;
  logic [1:0] nxt_code;

  // Output stage may be refilled in the same cycle it drains, so no bubble.
  assign bus.in_ready = (state == EMPTY) | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign nxt_hit      = |bus.d;
  assign multi_hot    = (bus.d & (bus.d - 4'd1)) != 4'd0;
  assign nxt_err      = ~nxt_hit | ((MULTI_HOT_ERR != 0) & multi_hot);

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  always_comb begin
    nxt_code = 2'b00;
    // Walk from farthest to nearest so the line closest to rr_ptr is assigned last and wins.
    for (int i = 3; i >= 0; i--) begin
      if (bus.d[rr_ptr + 2'(i)]) nxt_code = rr_ptr + 2'(i);
    end
  end
`else
  always_comb begin
    nxt_code = 2'b00;
    casez (bus.d)
      4'b1???: nxt_code = 2'b11;
      4'b01??: nxt_code = 2'b10;
      4'b001?: nxt_code = 2'b01;
      default: nxt_code = 2'b00;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      bus.out_valid <= 1'b0;
      bus.code      <= 2'b00;
      bus.hit       <= 1'b0;
      bus.err       <= 1'b0;
      err_cnt       <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr        <= 2'b00;
`endif
    end else if (accept) begin
      state         <= FULL;
      bus.out_valid <= 1'b1;
      bus.code      <= nxt_code;
      bus.hit       <= nxt_hit;
      bus.err       <= nxt_err;
      if (nxt_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
`ifdef ROUND_ROBIN_EN
      if (nxt_hit) rr_ptr <= nxt_code + 2'd1;
`endif
    end else if ((state == FULL) && bus.out_ready) begin
      state         <= EMPTY;
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_encoder_4x2_seq.sv
// tb/tb_encoder_4x2_seq.sv - self-checking bench for encoder_4x2_seq (default and alternate parameters)
module tb_encoder_4x2_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  encoder_4x2_seq_if bus_a ();
  encoder_4x2_seq_if bus_b ();
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  encoder_4x2_seq #(.MULTI_HOT_ERR(1), .ERR_CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .err_cnt(err_cnt_a)
  );
  encoder_4x2_seq #(.MULTI_HOT_ERR(0), .ERR_CNT_W(2)) u_alt (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .err_cnt(err_cnt_b)
  );

  typedef struct packed {
    logic [1:0] code;
    logic       hit;
    logic       err_a;
    logic       err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
  } exp_t;

  typedef struct packed {
    logic [3:0] d;
    logic [1:0] code;
    logic       hit;
    logic       err_a;
    logic       err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [7:0] m_cnt_a;
  logic [1:0] m_cnt_b;
`ifdef ROUND_ROBIN_EN
  logic [1:0] m_ptr;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void push_model(input logic [3:0] dv);
    exp_t e;
    logic [1:0] c;
    logic h;
    logic mh;
    c = 2'b00;
    h = (dv != 4'b0000);
    mh = ($countones(dv) > 1);
`ifdef ROUND_ROBIN_EN
    begin
      logic [7:0] dd;
      logic [3:0] r;
      int pos;
      dd = {dv, dv};
      r = dd[m_ptr +: 4];
      pos = 0;
      for (int j = 3; j >= 0; j--) if (r[j]) pos = j;
      if (h) c = m_ptr + 2'(pos);
      if (h) m_ptr = c + 2'd1;
    end
`else
    for (int j = 0; j < 4; j++) if (dv[j]) c = 2'(j);
`endif
    e.code  = c;
    e.hit   = h;
    e.err_a = !h || mh;
    e.err_b = !h;
    if (e.err_a && m_cnt_a != 8'hff) m_cnt_a = m_cnt_a + 8'd1;
    if (e.err_b && m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 2'd1;
    e.cnt_a = m_cnt_a;
    e.cnt_b = m_cnt_b;
    sb.push_back(e);
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow actual=out_valid required=no_result");
    end else begin
      e = sb.pop_front();
      chk("sb_code", bus_a.code, e.code);
      chk("sb_hit", bus_a.hit, e.hit);
      chk("sb_err_a", bus_a.err, e.err_a);
      chk("sb_err_b", bus_b.err, e.err_b);
      chk("sb_cnt_a", err_cnt_a, e.cnt_a);
      chk("sb_cnt_b", err_cnt_b, e.cnt_b);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] dv, input logic ordy);
    bus_a.in_valid  = v;
    bus_b.in_valid  = v;
    bus_a.d         = dv;
    bus_b.d         = dv;
    bus_a.out_ready = ordy;
    bus_b.out_ready = ordy;
  endtask

  // Called at a negedge after drive(); handles both handshakes of the coming edge.
  task automatic tick();
    bit acc;
    bit ohs;
    #1;
    acc = bus_a.in_valid & bus_a.in_ready;
    ohs = bus_a.out_valid & bus_a.out_ready;
    if (ohs) pop_check();
    if (acc) push_model(bus_a.d);
    @(posedge clk);
    @(negedge clk);
    if (acc) chk("latency_valid", bus_a.out_valid, 1);
  endtask

  task automatic model_clear();
    sb.delete();
    m_cnt_a = 8'd0;
    m_cnt_b = 2'd0;
`ifdef ROUND_ROBIN_EN
    m_ptr = 2'd0;
`endif
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [1:0] mh_code;
    logic [3:0] rr_d [6];
    logic [1:0] rr_code [6];

`ifdef ROUND_ROBIN_EN
    mh_code = 2'b01;
    rr_code = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
`else
    mh_code = 2'b11;
    rr_code = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
`endif
    rr_d = '{4'b1111, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
    tbl[0] = '{4'b0001, 2'b00,   1'b1, 1'b0, 1'b0, 8'd0, 2'd0};
    tbl[1] = '{4'b0010, 2'b01,   1'b1, 1'b0, 1'b0, 8'd0, 2'd0};
    tbl[2] = '{4'b0100, 2'b10,   1'b1, 1'b0, 1'b0, 8'd0, 2'd0};
    tbl[3] = '{4'b1000, 2'b11,   1'b1, 1'b0, 1'b0, 8'd0, 2'd0};
    tbl[4] = '{4'b0000, 2'b00,   1'b0, 1'b1, 1'b1, 8'd1, 2'd1};
    tbl[5] = '{4'b1010, mh_code, 1'b1, 1'b1, 1'b0, 8'd2, 2'd1};

    rst_n = 1'b0;
    model_clear();
    drive(1'b0, 4'b0000, 1'b0);
    do_reset();
    #1;
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_code", bus_a.code, 0);
    chk("rst_hit", bus_a.hit, 0);
    chk("rst_err", bus_a.err, 0);
    chk("rst_cnt_a", err_cnt_a, 0);
    chk("rst_cnt_b", err_cnt_b, 0);
    chk("rst_in_ready", bus_a.in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].d, 1'b1);
      tick();
      chk($sformatf("tbl%0d_code", i), bus_a.code, tbl[i].code);
      chk($sformatf("tbl%0d_hit", i), bus_a.hit, tbl[i].hit);
      chk($sformatf("tbl%0d_err_a", i), bus_a.err, tbl[i].err_a);
      chk($sformatf("tbl%0d_err_b", i), bus_b.err, tbl[i].err_b);
      chk($sformatf("tbl%0d_cnt_a", i), err_cnt_a, tbl[i].cnt_a);
      chk($sformatf("tbl%0d_cnt_b", i), err_cnt_b, tbl[i].cnt_b);
    end
    drive(1'b0, 4'bxxxx, 1'b1);
    tick();
    chk("drain_valid", bus_a.out_valid, 0);
    chk("idle_x_code", bus_a.code, mh_code);

    drive(1'b1, 4'b0100, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'b0);
      #1;
      chk("bp_in_ready", bus_a.in_ready, 0);
      tick();
      chk("bp_code", bus_a.code, 2'b10);
      chk("bp_valid", bus_a.out_valid, 1);
    end
    drive(1'b1, 4'b0001, 1'b1);
    tick();
    chk("b2b_code", bus_a.code, 2'b00);
    chk("b2b_valid", bus_a.out_valid, 1);
    drive(1'b0, 4'bxxxx, 1'b1);
    tick();

    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b0000, 1'b1);
      tick();
      chk($sformatf("sat%0d_cnt_b", k), err_cnt_b, (k < 3) ? k + 1 : 3);
      chk($sformatf("sat%0d_cnt_a", k), err_cnt_a, k + 1);
    end
    drive(1'b0, 4'bxxxx, 1'b1);
    tick();

    drive(1'b1, 4'b1000, 1'b1);
    tick();
    drive(1'b0, 4'bxxxx, 1'b0);
    chk("arst_pre_code", bus_a.code, 2'b11);
    chk("arst_pre_cnt_a", err_cnt_a, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus_a.out_valid, 0);
    chk("arst_code", bus_a.code, 0);
    chk("arst_cnt_a", err_cnt_a, 0);
    chk("arst_cnt_b", err_cnt_b, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'b0010, 1'b1);
    tick();
    chk("arst_after_code", bus_a.code, 2'b01);
    drive(1'b0, 4'bxxxx, 1'b1);
    tick();

    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, rr_d[k], 1'b1);
      tick();
      chk($sformatf("rr%0d_code", k), bus_a.code, rr_code[k]);
    end
    drive(1'b0, 4'bxxxx, 1'b1);
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
